unidad_busqueda: RTL and testbench
==================================

# unidad_busqueda

Instruction-fetch stage of the single-cycle-memory CPU. It owns the program counter, drives the byte address into the combinational, big-endian, 1 KiB instruction memory, and captures the returned 32-bit word into the IF/ID pipeline register for the decoder. It also applies branch/jump redirects, stalls, flushes and halts, and keeps a fetched-instruction counter.

## Interface
- `RESET_PC`, 32'd0, PC value loaded at reset; must be word aligned.
- `MEM_BYTES`, 1024, instruction memory size in bytes; power of two, at least 8.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold PC and IF/ID contents (load-use hazard from decode).
- `flush`  in  1  load a bubble into IF/ID on the next edge.
- `branch_taken`  in  1  redirect to `branch_target` (resolved in EX).
- `branch_target`  in  32  byte address of the branch destination.
- `jump`  in  1  J-type redirect.
- `jump_index`  in  26  J-type index field.
- `halt`  in  1  enter ALTO (one-cycle pulse is enough).
- `reanudar`  in  1  leave ALTO.
- `instruccion_in`  in  32  word returned by the instruction memory for `pc_out`.
- `pc_out`  out  32  registered byte address to the instruction memory.
- `if_id_instr`  out  32  latched instruction.
- `if_id_pc4`  out  32  PC+4 of the latched instruction.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `fetch_count`  out  32  number of instructions latched valid since reset.

## Operation
- State machine:
  - **ARRANQUE**: entered on reset. Lasts one cycle. No latch; PC held. Moves to CORRE.
  - **CORRE**: normal fetch.
  - **ALTO**: PC frozen, IF/ID gets bubbles. Moves to CORRE on `reanudar`. Reset is the only other exit.
- Address masking: every PC value written is `addr & (MEM_BYTES-1) & ~3`. Misaligned or out-of-range targets are silently aligned and wrapped.
- Sequential next PC is `(pc_out + 4) mod MEM_BYTES`. With `MEM_BYTES`=1024, 1020 wraps to 0.
- Jump target is `{pc4[31:28], jump_index, 2'b00}`, then masked. `pc4` is `if_id_pc4`, the PC+4 of the jump being decoded.
- Priority in CORRE, highest first:
  1. `halt`: go to ALTO, PC held, bubble.
  2. `branch_taken`: PC ← masked `branch_target`, bubble.
  3. `jump`: PC ← jump target, bubble.
  4. `stall`: PC and IF/ID held, `fetch_count` held.
  5. `flush`: PC advances, bubble.
  6. Otherwise: latch `instruccion_in`, set `if_id_pc4` = `pc_out`+4 (masked), set valid = 1, advance PC.
- A redirect overrides a simultaneous `stall`.
- `branch_taken` and `jump` together: the branch wins.
- `reanudar` together with `halt` while in ALTO: the machine stays in ALTO.
- A bubble is `if_id_instr`=0, `if_id_valid`=0. `if_id_pc4` is not changed by a bubble.
- `fetch_count` increments only on case 6 and wraps at 2^32.

## Timing
- Reset values:
  - `pc_out`=`RESET_PC`
  - `if_id_instr`=0
  - `if_id_pc4`=0
  - `if_id_valid`=0
  - `fetch_count`=0
  - state ARRANQUE
- Reset is asynchronous: all of the above apply immediately, mid-operation included.
- The instruction memory is combinational. The word for `pc_out` in cycle N appears on `if_id_instr` after edge N+1.
- After reset deassertion:
  - edge 1: ARRANQUE → CORRE.
  - edge 2: latch the word at `RESET_PC`; `pc_out` becomes `RESET_PC`+4.
- A redirect sampled at edge N changes `pc_out` at edge N. The target instruction is valid in IF/ID after edge N+1, so exactly one bubble is inserted.
- Stall adds no latency beyond the held cycles; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `cpu_pkg` holds:
  - the state enum (ARRANQUE, CORRE, ALTO)
  - `NOP_INSTR` = 32'h0
  - `WORD_BYTES` = 4
  - the J-type field widths (opcode 6, index 26)
- One sub-module is natural: `registro_if_id`, the IF/ID register with hold/bubble/load controls.
- The PC, next-PC mux and FSM live in the top module.

## Test plan
- **Reset and sequential fetch**: reset, memory words at 0/4/8 = 32'h00611820/32'h01CCF022/32'h03FEE81A. Required: `if_id_instr` shows the three words on consecutive cycles, `if_id_pc4` = 4/8/12, `fetch_count` = 3.
- **Wrap-around**: with PC at 1016, run 3 cycles. Required: `pc_out` goes 1020 → 0 → 4.
- **Branch with simultaneous stall and jump**: assert `branch_taken`=1 (target 32'h7D, misaligned), `stall`=1 and `jump`=1 in the same cycle. Required: `pc_out`=124, one bubble, then the word at 124 is latched valid.
- **Jump**: `if_id_pc4`=32'h68, `jump_index`=26'h1F. Required: `pc_out`=32'h7C, one bubble.
- **Stall then flush**: 3 cycles of `stall` hold `pc_out`, IF/ID and count unchanged. A following `flush` gives valid=0 and PC+4.
- **Halt, resume, reset mid-operation**: pulse `halt` → PC frozen, valid=0 for 5 cycles. `reanudar` → fetch resumes at the frozen PC. Then assert `rst_n`=0 mid-cycle → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: types and constants shared by the instruction-fetch stage.
//   estado_t   : fetch FSM states (ARRANQUE after reset, CORRE fetching, ALTO halted)
//   NOP_INSTR  : word loaded into IF/ID for a bubble
//   WORD_BYTES : instruction size in bytes
//   OPCODE_W / INDEX_W : J-type field widths
package cpu_pkg;

  typedef enum logic [1:0] {
    ARRANQUE = 2'd0,
    CORRE    = 2'd1,
    ALTO     = 2'd2
  } estado_t;

  localparam logic [31:0] NOP_INSTR  = 32'h0;
  localparam int          WORD_BYTES = 4;
  localparam int          OPCODE_W   = 6;
  localparam int          INDEX_W    = 26;

endpackage

// File: rtl/registro_if_id.sv
// registro_if_id: IF/ID pipeline register.
//   clk, rst_n     : clock, async active-low reset
//   load           : capture instr_in / pc4_in, mark valid
//   bubble         : load NOP, clear valid, keep pc4
//   (neither)      : hold contents
//   instr_in, pc4_in : fetched word and its PC+4
//   instr, pc4, valid : registered outputs to decode
module registro_if_id
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  // load wins over bubble; the caller never asserts both.
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (load) begin
      instr_d = instr_in;
      pc4_d   = pc4_in;
      valid_d = 1'b1;
    end else if (bubble) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr = instr_q;
  assign pc4   = pc4_q;
  assign valid = valid_q;

endmodule

// File: rtl/unidad_busqueda.sv
// unidad_busqueda: instruction-fetch stage.
//   Owns the PC, selects the next PC (sequential / branch / jump / hold),
//   runs the ARRANQUE/CORRE/ALTO state machine and counts valid fetches.
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   stall, flush                    : hazard controls from decode
//   branch_taken, branch_target     : EX-resolved branch redirect
//   jump, jump_index                : J-type redirect
//   halt, reanudar                  : enter / leave ALTO
//   instruccion_in                  : memory word for pc_out (combinational memory)
//   pc_out                          : registered fetch address
//   if_id_instr/pc4/valid           : IF/ID register contents
//   fetch_count                     : instructions latched valid since reset
module unidad_busqueda
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int          MEM_BYTES = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                flush,
  input  logic                branch_taken,
  input  logic [31:0]         branch_target,
  input  logic                jump,
  input  logic [INDEX_W-1:0]  jump_index,
  input  logic                halt,
  input  logic                reanudar,
  input  logic [31:0]         instruccion_in,
  output logic [31:0]         pc_out,
  output logic [31:0]         if_id_instr,
  output logic [31:0]         if_id_pc4,
  output logic                if_id_valid,
  output logic [31:0]         fetch_count
);

  // Every PC value written is wrapped into the memory and word aligned.
  localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1) & ~32'(WORD_BYTES - 1);

  function automatic logic [31:0] mask_addr(input logic [31:0] a);
    return a & ADDR_MASK;
  endfunction

  estado_t     state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        ld, bub;
  logic [31:0] pc_seq, jmp_tgt;

  assign pc_seq  = mask_addr(pc_q + 32'(WORD_BYTES));
  // Upper nibble comes from PC+4 of the jump sitting in IF/ID.
  assign jmp_tgt = mask_addr({if_id_pc4[31:28], jump_index, 2'b00});

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ld      = 1'b0;
    bub     = 1'b0;
    case (state_q)
      ARRANQUE: state_d = CORRE;
      CORRE: begin
        // Priority chain: halt > branch > jump > stall > flush > fetch.
        // Redirects therefore override a simultaneous stall.
        if (halt) begin
          state_d = ALTO;
          bub     = 1'b1;
        end else if (branch_taken) begin
          pc_d = mask_addr(branch_target);
          bub  = 1'b1;
        end else if (jump) begin
          pc_d = jmp_tgt;
          bub  = 1'b1;
        end else if (stall) begin
          // hold everything
        end else if (flush) begin
          pc_d = pc_seq;
          bub  = 1'b1;
        end else begin
          ld    = 1'b1;
          pc_d  = pc_seq;
          cnt_d = cnt_q + 32'd1;
        end
      end
      ALTO: begin
        bub = 1'b1;
        // A fresh halt alongside reanudar keeps the machine stopped.
        if (reanudar && !halt) state_d = CORRE;
      end
      default: state_d = ARRANQUE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARRANQUE;
      pc_q    <= RESET_PC;
      cnt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  registro_if_id u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ld),
    .bubble   (bub),
    .instr_in (instruccion_in),
    .pc4_in   (pc_seq),
    .instr    (if_id_instr),
    .pc4      (if_id_pc4),
    .valid    (if_id_valid)
  );

  assign pc_out      = pc_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_unidad_busqueda.sv
module tb_unidad_busqueda;

  localparam int MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, branch_taken = 1'b0, jump = 1'b0;
  logic        halt = 1'b0, reanudar = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [25:0] jump_index = 26'h0;
  logic [31:0] instruccion_in;
  logic [31:0] pc_out, if_id_instr, if_id_pc4, fetch_count;
  logic        if_id_valid;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:MEM_BYTES/4-1];

  always #5 clk = ~clk;

  assign instruccion_in = mem[pc_out[9:2]];

  unidad_busqueda #(.RESET_PC(32'd0), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_index(jump_index), .halt(halt), .reanudar(reanudar),
    .instruccion_in(instruccion_in), .pc_out(pc_out), .if_id_instr(if_id_instr),
    .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .fetch_count(fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integer arithmetic on byte addresses.
  int unsigned m_pc, m_pc4, m_instr, m_cnt;
  bit          m_valid, m_starting, m_halted;

  function automatic int unsigned wrap_align(input longint unsigned a);
    return int'(((a % MEM_BYTES) / 4) * 4);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 0; m_pc4 = 0; m_instr = 0; m_valid = 0; m_cnt = 0;
      m_starting = 1; m_halted = 0;
    end else if (m_starting) begin
      m_starting = 0;
    end else if (m_halted) begin
      m_instr = 0; m_valid = 0;
      if (reanudar && !halt) m_halted = 0;
    end else if (halt) begin
      m_halted = 1; m_instr = 0; m_valid = 0;
    end else if (branch_taken) begin
      m_pc = wrap_align(branch_target); m_instr = 0; m_valid = 0;
    end else if (jump) begin
      m_pc = wrap_align((m_pc4 / 32'h1000_0000) * 32'h1000_0000 + jump_index * 4);
      m_instr = 0; m_valid = 0;
    end else if (stall) begin
    end else if (flush) begin
      m_pc = wrap_align(m_pc + 4); m_instr = 0; m_valid = 0;
    end else begin
      m_instr = mem[m_pc / 4];
      m_pc4   = wrap_align(m_pc + 4);
      m_pc    = m_pc4;
      m_valid = 1;
      m_cnt   = m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    chk("pc_out", pc_out, m_pc);
    chk("if_id_instr", if_id_instr, m_instr);
    chk("if_id_pc4", if_id_pc4, m_pc4);
    chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
    chk("fetch_count", fetch_count, m_cnt);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < MEM_BYTES/4; i++) mem[i] = 32'hC000_0000 + i * 32'h0001_0003;
    mem[0] = 32'h00611820;
    mem[1] = 32'h01CCF022;
    mem[2] = 32'h03FEE81A;

    // Reset state
    #2;
    chk("rst pc", pc_out, 32'd0);
    chk("rst instr", if_id_instr, 32'd0);
    chk("rst pc4", if_id_pc4, 32'd0);
    chk("rst valid", {31'b0, if_id_valid}, 32'd0);
    chk("rst cnt", fetch_count, 32'd0);
    tick();
    rst_n = 1'b1;

    // Sequential fetch: edge 1 is ARRANQUE, edges 2..4 fetch
    tick();
    chk("boot pc held", pc_out, 32'd0);
    chk("boot valid", {31'b0, if_id_valid}, 32'd0);
    tick();
    chk("seq0 instr", if_id_instr, 32'h00611820);
    chk("seq0 pc4", if_id_pc4, 32'd4);
    tick();
    chk("seq1 instr", if_id_instr, 32'h01CCF022);
    chk("seq1 pc4", if_id_pc4, 32'd8);
    tick();
    chk("seq2 instr", if_id_instr, 32'h03FEE81A);
    chk("seq2 pc4", if_id_pc4, 32'd12);
    chk("seq cnt", fetch_count, 32'd3);
    chk("seq valid", {31'b0, if_id_valid}, 32'd1);

    // Wrap-around from 1016
    branch_taken = 1'b1; branch_target = 32'd1016;
    tick();
    branch_taken = 1'b0;
    chk("wrap start", pc_out, 32'd1016);
    tick(); chk("wrap 1020", pc_out, 32'd1020);
    tick(); chk("wrap 0", pc_out, 32'd0);
    chk("wrap pc4", if_id_pc4, 32'd0);
    tick(); chk("wrap 4", pc_out, 32'd4);

    // Branch beats simultaneous stall and jump; misaligned target aligned
    branch_taken = 1'b1; branch_target = 32'h7D; stall = 1'b1; jump = 1'b1; jump_index = 26'h3;
    tick();
    branch_taken = 1'b0; stall = 1'b0; jump = 1'b0;
    chk("br pc", pc_out, 32'd124);
    chk("br bubble", {31'b0, if_id_valid}, 32'd0);
    chk("br bubble instr", if_id_instr, 32'd0);
    tick();
    chk("br instr", if_id_instr, 32'hC000_0000 + 31 * 32'h0001_0003);
    chk("br valid", {31'b0, if_id_valid}, 32'd1);
    chk("br pc4", if_id_pc4, 32'd128);

    // Jump with if_id_pc4 = 0x68
    branch_taken = 1'b1; branch_target = 32'h64;
    tick();
    branch_taken = 1'b0;
    tick();
    chk("jmp pre pc4", if_id_pc4, 32'h68);
    jump = 1'b1; jump_index = 26'h1F;
    tick();
    jump = 1'b0;
    chk("jmp pc", pc_out, 32'h7C);
    chk("jmp bubble", {31'b0, if_id_valid}, 32'd0);
    tick();
    chk("jmp pc next", pc_out, 32'h80);

    // Stall 3 cycles then flush
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    chk("stall pc", pc_out, 32'h80);
    chk("stall instr", if_id_instr, 32'hC000_0000 + 31 * 32'h0001_0003);
    chk("stall valid", {31'b0, if_id_valid}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush pc", pc_out, 32'h84);
    chk("flush valid", {31'b0, if_id_valid}, 32'd0);
    chk("flush pc4 kept", if_id_pc4, 32'h80);
    tick();

    // Halt pulse, hold, halt+reanudar stays, resume
    halt = 1'b1;
    tick();
    halt = 1'b0;
    repeat (5) begin
      tick();
      chk("halt pc", pc_out, 32'h88);
      chk("halt valid", {31'b0, if_id_valid}, 32'd0);
    end
    halt = 1'b1; reanudar = 1'b1;
    tick();
    halt = 1'b0; reanudar = 1'b0;
    tick();
    chk("halt+res pc", pc_out, 32'h88);
    reanudar = 1'b1;
    tick();
    reanudar = 1'b0;
    tick();
    chk("resume instr", if_id_instr, 32'hC000_0000 + 34 * 32'h0001_0003);
    chk("resume pc", pc_out, 32'h8C);
    tick();

    // Asynchronous reset mid-cycle
    #1 rst_n = 1'b0;
    #1;
    chk("arst pc", pc_out, 32'd0);
    chk("arst instr", if_id_instr, 32'd0);
    chk("arst pc4", if_id_pc4, 32'd0);
    chk("arst valid", {31'b0, if_id_valid}, 32'd0);
    chk("arst cnt", fetch_count, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("post rst cnt", fetch_count, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
